top: RTL and testbench

TOP -- requirements
Module: top

---
 rtl/top.sv | 170 +++++++++++++++++
 tb/tb_top.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/top.sv
// Purpose: 4x4 output-stationary systolic matrix-multiply engine with operand, instruction and result stores.
// Latency: each instruction takes FETCH + (K+6 or K+7) STREAM cycles + STORE; ap_done follows the final FETCH.
// Backpressure: none; store writes are accepted every cycle and ap_start is ignored while a program runs.
module top (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  addrA,
  input  logic [15:0] dataA,
  input  logic        enA,
  input  logic [9:0]  addrB,
  input  logic [15:0] dataB,
  input  logic        enB,
  input  logic [2:0]  addrI,
  input  logic [4:0]  dataI,
  input  logic        enI,
  input  logic [6:0]  addrO,
  output logic [31:0] dataO,
  input  logic        ap_start,
  output logic        ap_done,
  output logic [4:0]  currInstruction
);

  typedef enum logic [2:0] {IDLE, FETCH, STREAM, STORE, DONE} state_t;

  state_t      state;
  logic [3:0]  i_idx;     // instruction index, reaches 8 to end a full program
  logic [7:0]  p;         // operand column pointer, wraps past 255
  logic [5:0]  len;       // remaining STREAM cycles
  logic [4:0]  fetch_word;

  // Stores are never reset so their contents survive rst
  logic [15:0] a_mem     [4][256];
  logic [15:0] b_mem     [4][256];
  logic [4:0]  instr_mem [8];
  logic [31:0] res_mem   [128];

  // PE pipeline registers, edge inputs and accumulators
  logic [15:0] a_reg [4][4];
  logic [15:0] b_reg [4][4];
  logic [15:0] a_in  [4][4];
  logic [15:0] b_in  [4][4];
  logic [31:0] prod  [4][4];
  logic [31:0] acc   [4][4];

  assign fetch_word = instr_mem[i_idx[2:0]];
  assign dataO      = res_mem[addrO];

  // Host write ports for the operand and instruction stores
  always_ff @(posedge clk) begin
    if (enA) a_mem[addrA[9:8]][addrA[7:0]] <= dataA;
    if (enB) b_mem[addrB[9:8]][addrB[7:0]] <= dataB;
    if (enI) instr_mem[addrI] <= dataI;
  end

  // Unload all 16 accumulators into the result window of the current instruction
  always_ff @(posedge clk) begin
    if (!rst && state == STORE) begin
      for (int r = 0; r < 4; r++) begin
        for (int c = 0; c < 4; c++) begin
          res_mem[{i_idx[2:0], 2'(r), 2'(c)}] <= acc[r][c];
        end
      end
    end
  end

  // PE operand routing: column p enters at the edges, otherwise take the neighbour's register
  always_comb begin
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        a_in[r][c] = 16'd0;
        b_in[r][c] = 16'd0;
        prod[r][c] = 32'd0;
      end
    end
    for (int r = 0; r < 4; r++) begin
      a_in[r][0] = a_mem[r][p];
      for (int c = 1; c < 4; c++) begin
        a_in[r][c] = a_reg[r][c-1];
      end
    end
    for (int c = 0; c < 4; c++) begin
      b_in[0][c] = b_mem[c][p];
      for (int r = 1; r < 4; r++) begin
        b_in[r][c] = b_reg[r-1][c];
      end
    end
    // Sign-extend to 32 bits; the low 32 product bits give the wrapped signed result
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        prod[r][c] = {{16{a_in[r][c][15]}}, a_in[r][c]} * {{16{b_in[r][c][15]}}, b_in[r][c]};
      end
    end
  end

  // PE array: clear between instructions, shift operands and accumulate while streaming
  always_ff @(posedge clk) begin
    if (rst || state == FETCH) begin
      for (int r = 0; r < 4; r++) begin
        for (int c = 0; c < 4; c++) begin
          a_reg[r][c] <= 16'd0;
          b_reg[r][c] <= 16'd0;
          acc[r][c]   <= 32'd0;
        end
      end
    end else if (state == STREAM) begin
      for (int r = 0; r < 4; r++) begin
        for (int c = 0; c < 4; c++) begin
          a_reg[r][c] <= a_in[r][c];
          b_reg[r][c] <= b_in[r][c];
          acc[r][c]   <= acc[r][c] + prod[r][c];
        end
      end
    end
  end

  // Program sequencer with registered ap_done and currInstruction
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      ap_done         <= 1'b0;
      currInstruction <= 5'd0;
      i_idx           <= 4'd0;
      p               <= 8'd0;
      len             <= 6'd0;
    end else begin
      case (state)
        IDLE: begin
          ap_done         <= 1'b0;
          currInstruction <= 5'd0;
          if (ap_start) begin
            i_idx <= 4'd0;
            p     <= 8'd0;
            state <= FETCH;
          end
        end
        FETCH: begin
          if (i_idx == 4'd8 || fetch_word == 5'd0) begin
            currInstruction <= 5'd0;
            ap_done         <= 1'b1;
            state           <= DONE;
          end else begin
            currInstruction <= fetch_word;
            // Later instructions carry one extra column of pipeline slack
            len   <= (i_idx == 4'd0) ? 6'(fetch_word) + 6'd6 : 6'(fetch_word) + 6'd7;
            state <= STREAM;
          end
        end
        STREAM: begin
          p   <= p + 8'd1;
          len <= len - 6'd1;
          if (len == 6'd1) state <= STORE;
        end
        STORE: begin
          i_idx <= i_idx + 4'd1;
          state <= FETCH;
        end
        DONE: begin
          ap_done <= 1'b0;
          state   <= IDLE;
        end
        default: begin
          ap_done         <= 1'b0;
          currInstruction <= 5'd0;
          state           <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_top.sv
// Purpose: directed self-checking bench for the systolic matrix engine.
// Latency: waits on ap_done with a bounded cycle budget per program.
// Backpressure: not applicable; stimulus is driven on falling edges.
module tb_top;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  addrA, addrB;
  logic [15:0] dataA, dataB;
  logic        enA, enB;
  logic [2:0]  addrI;
  logic [4:0]  dataI;
  logic        enI;
  logic [6:0]  addrO;
  logic [31:0] dataO;
  logic        ap_start;
  logic        ap_done;
  logic [4:0]  currInstruction;

  int n_cmp = 0;
  int n_bad = 0;
  logic [4:0] prog [8];

  always #5 clk = ~clk;

  top dut (
    .clk(clk), .rst(rst),
    .addrA(addrA), .dataA(dataA), .enA(enA),
    .addrB(addrB), .dataB(dataB), .enB(enB),
    .addrI(addrI), .dataI(dataI), .enI(enI),
    .addrO(addrO), .dataO(dataO),
    .ap_start(ap_start), .ap_done(ap_done), .currInstruction(currInstruction)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wr_ab(input int r, input int col, input logic [15:0] va, input logic [15:0] vb);
    @(negedge clk);
    addrA = {r[1:0], col[7:0]}; dataA = va; enA = 1'b1;
    addrB = {r[1:0], col[7:0]}; dataB = vb; enB = 1'b1;
  endtask

  task automatic wr_end();
    @(negedge clk);
    enA = 1'b0; enB = 1'b0; enI = 1'b0;
  endtask

  task automatic clear_ab();
    for (int col = 0; col < 64; col++)
      for (int r = 0; r < 4; r++)
        wr_ab(r, col, 16'd0, 16'd0);
    wr_end();
  endtask

  task automatic load_prog();
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      addrI = 3'(k); dataI = prog[k]; enI = 1'b1;
    end
    wr_end();
  endtask

  task automatic rd_res(input int idx, output logic [31:0] v);
    addrO = 7'(idx);
    #1;
    v = dataO;
  endtask

  // Start a program; optionally re-pulse ap_start at cycle pulse_at; returns cycles to ap_done
  task automatic run_prog(input int pulse_at, output int cyc, output logic [4:0] mid_ci);
    cyc = -1;
    mid_ci = 5'd0;
    @(negedge clk); ap_start = 1'b1;
    @(negedge clk); ap_start = 1'b0;
    for (int n = 1; n <= 3000; n++) begin
      @(negedge clk);
      if (n == 3) mid_ci = currInstruction;
      ap_start = (n == pulse_at);
      if (ap_done) begin
        cyc = n;
        break;
      end
    end
    ap_start = 1'b0;
    chk("done_seen", 32'(cyc >= 0), 32'd1);
    chk("ci_at_done", 32'(currInstruction), 32'd0);
    @(negedge clk);
    chk("done_width", 32'(ap_done), 32'd0);
  endtask

  function automatic int a0(int r, int k); return r * 3 - k * 2 + 1; endfunction
  function automatic int b0(int k, int c); return k * 4 - c + 2;     endfunction
  function automatic int a1(int r, int k); return r - k * 3 - 2;     endfunction
  function automatic int b1(int k, int c); return c * 2 + k - 1;     endfunction

  initial begin
    int cyc;
    logic [4:0] ci;
    logic [31:0] v;
    int s;
    bit seen;

    rst = 1'b1; enA = 1'b0; enB = 1'b0; enI = 1'b0; ap_start = 1'b0;
    addrA = '0; addrB = '0; dataA = '0; dataB = '0; addrI = '0; dataI = '0; addrO = '0;
    repeat (3) @(negedge clk);
    chk("rst_done", 32'(ap_done), 32'd0);
    chk("rst_ci", 32'(currInstruction), 32'd0);
    rst = 1'b0;

    // All-ones K=4, skewed
    clear_ab();
    for (int r = 0; r < 4; r++)
      for (int k = 0; k < 4; k++)
        wr_ab(r, r + k, 16'd1, 16'd1);
    wr_end();
    for (int k = 0; k < 8; k++) prog[k] = 5'd0;
    prog[0] = 5'd4;
    load_prog();
    run_prog(-1, cyc, ci);
    chk("ones_cycles", 32'(cyc), 32'd13);
    chk("ones_ci", 32'(ci), 32'd4);
    for (int j = 0; j < 16; j++) begin
      rd_res(j, v);
      chk($sformatf("ones_res%0d", j), v, 32'd4);
    end

    // Two instructions K=2 (cols 0..7) and K=3 (cols 8..17), with an ignored mid-stream start
    clear_ab();
    for (int r = 0; r < 4; r++)
      for (int k = 0; k < 2; k++)
        wr_ab(r, r + k, 16'(a0(r, k)), 16'(b0(k, r)));
    for (int r = 0; r < 4; r++)
      for (int k = 0; k < 3; k++)
        wr_ab(r, 8 + r + k, 16'(a1(r, k)), 16'(b1(k, r)));
    wr_end();
    prog[0] = 5'd2; prog[1] = 5'd3;
    load_prog();
    run_prog(5, cyc, ci);
    chk("two_cycles", 32'(cyc), 32'd23);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        s = 0;
        for (int k = 0; k < 2; k++) s += a0(r, k) * b0(k, c);
        rd_res(4 * r + c, v);
        chk($sformatf("two_i0_%0d_%0d", r, c), v, 32'(s));
        s = 0;
        for (int k = 0; k < 3; k++) s += a1(r, k) * b1(k, c);
        rd_res(16 + 4 * r + c, v);
        chk($sformatf("two_i1_%0d_%0d", r, c), v, 32'(s));
      end

    // Signed K=1: -3 * 5; results 16..31 must survive
    clear_ab();
    for (int r = 0; r < 4; r++) wr_ab(r, r, 16'hFFFD, 16'd5);
    wr_end();
    prog[0] = 5'd1; prog[1] = 5'd0;
    load_prog();
    run_prog(-1, cyc, ci);
    for (int j = 0; j < 16; j++) begin
      rd_res(j, v);
      chk($sformatf("neg_res%0d", j), v, 32'hFFFF_FFF1);
    end
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        s = 0;
        for (int k = 0; k < 3; k++) s += a1(r, k) * b1(k, c);
        rd_res(16 + 4 * r + c, v);
        chk($sformatf("keep_%0d_%0d", r, c), v, 32'(s));
      end

    // Overflow K=31, all operands -32768
    clear_ab();
    for (int r = 0; r < 4; r++)
      for (int k = 0; k < 31; k++)
        wr_ab(r, r + k, 16'h8000, 16'h8000);
    wr_end();
    prog[0] = 5'd31;
    load_prog();
    run_prog(-1, cyc, ci);
    chk("ovf_cycles", 32'(cyc), 32'd40);
    for (int j = 0; j < 16; j++) begin
      rd_res(j, v);
      chk($sformatf("ovf_res%0d", j), v, 32'hC000_0000);
    end

    // Reset mid-stream aborts without ap_done
    @(negedge clk); ap_start = 1'b1;
    @(negedge clk); ap_start = 1'b0;
    repeat (10) @(negedge clk);
    chk("pre_rst_ci", 32'(currInstruction), 32'd31);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_ci", 32'(currInstruction), 32'd0);
    chk("mid_rst_done", 32'(ap_done), 32'd0);
    rst = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (ap_done) seen = 1'b1;
    end
    chk("rst_no_done", 32'(seen), 32'd0);
    rd_res(0, v);
    chk("rst_res_kept", v, 32'hC000_0000);
    run_prog(-1, cyc, ci);
    chk("rerun_ci", 32'(ci), 32'd31);
    rd_res(15, v);
    chk("rerun_res15", v, 32'hC000_0000);

    // Empty program
    prog[0] = 5'd0;
    load_prog();
    run_prog(-1, cyc, ci);
    chk("empty_cycles", 32'(cyc), 32'd1);
    rd_res(0, v);
    chk("empty_res_kept", v, 32'hC000_0000);

    // Eight K=1 instructions; only the last window (cols 55..62) carries data
    clear_ab();
    for (int r = 0; r < 4; r++) wr_ab(r, 55 + r, 16'd2, 16'd3);
    wr_end();
    for (int k = 0; k < 8; k++) prog[k] = 5'd1;
    load_prog();
    run_prog(-1, cyc, ci);
    chk("full_cycles", 32'(cyc), 32'd80);
    rd_res(0, v);   chk("full_res0", v, 32'd0);
    rd_res(111, v); chk("full_res111", v, 32'd0);
    for (int j = 112; j < 128; j++) begin
      rd_res(j, v);
      chk($sformatf("full_res%0d", j), v, 32'd6);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
